clint_timer: RTL and testbench

Parametrised core-local interruptor (CLINT) for the RV32 pipeline: one shared 64-bit `mtime` with programmable prescaler, plus per-hart `mtimecmp` and `msip` registers on the core's single-cycle memory-mapped data bus. It replaces the single-hart timer.
- Multi-hart configurations get one timer, one software and one external interrupt line per hart.
- Byte strobes are honoured and the address map is relocatable.

---
 rtl/clint_pkg.sv | 21 ++
 rtl/clint_prescaler.sv | 27 ++
 rtl/clint_timer.sv | 202 ++++++++++++++++++++
 tb/tb_clint_timer.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - register map, hart limit and byte-lane merge shared by clint_timer
package clint_pkg;

  localparam int          MAX_HARTS    = 8;
  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] PRESCALE_OFF = 16'hBFF0;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  // Lanes with strb set take new_val, the rest keep old.
  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// rtl/clint_prescaler.sv - mtime tick generator, one tick every div+1 enabled cycles
module clint_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] div,
  input  logic         clr,
  output logic         tick
);

  logic [W-1:0] pcnt;

  assign tick = en && (pcnt == div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - multi-hart CLINT: shared prescaled mtime, per-hart mtimecmp/msip
// on a single-cycle memory-mapped bus with byte strobes.
module clint_timer
  import clint_pkg::*;
#(
  parameter int          NUM_HARTS  = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 timer_en,
  input  logic                 wready,
  output logic                 wvalid,
  input  logic [31:0]          waddr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  input  logic                 rready,
  output logic                 rvalid,
  input  logic [31:0]          raddr,
  output logic                 rresp,
  output logic [31:0]          rdata,
  output logic [NUM_HARTS-1:0] timer_irq,
  output logic [NUM_HARTS-1:0] sw_irq,
  output logic [NUM_HARTS-1:0] ex_irq
);

  localparam int HIDX_W = $clog2(MAX_HARTS);

  assign wvalid = 1'b1;
  assign rvalid = 1'b1;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{waddr[1:0], raddr[1:0]};

  // Write decode; the hart index field is sized for MAX_HARTS so that
  // indices at or beyond NUM_HARTS fall through as unmapped.
  logic              whit, wr_en;
  logic [15:0]       woff;
  logic [HIDX_W-1:0] w_msip_idx, w_cmp_idx;
  logic              w_msip_rgn, w_cmp_rgn;
  logic              wr_prescale, wr_mtime_lo, wr_mtime_hi;

  assign whit        = (waddr[31:16] == BASE_ADDR[31:16]);
  assign woff        = {waddr[15:2], 2'b00};
  assign wr_en       = wready && whit && (wstrb != 4'b0000);
  assign w_msip_idx  = woff[2 +: HIDX_W];
  assign w_cmp_idx   = woff[3 +: HIDX_W];
  assign w_msip_rgn  = (woff[15:2+HIDX_W] == MSIP_OFF[15:2+HIDX_W]);
  assign w_cmp_rgn   = (woff[15:3+HIDX_W] == MTIMECMP_OFF[15:3+HIDX_W]);
  assign wr_prescale = wr_en && (woff == PRESCALE_OFF);
  assign wr_mtime_lo = wr_en && (woff == MTIME_OFF);
  assign wr_mtime_hi = wr_en && (woff == MTIME_OFF + 16'd4);

  logic [PRESCALE_W-1:0] prescale_q;
  logic [31:0]           prescale_ext, prescale_merged;
  logic                  tick;

  assign prescale_ext    = 32'(prescale_q);
  assign prescale_merged = byte_merge(prescale_ext, wdata, wstrb);

  if (PRESCALE_W < 32) begin : g_prescale_pad
    logic unused_prescale_hi;
    assign unused_prescale_hi = ^prescale_merged[31:PRESCALE_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_q <= '0;
    end else if (wr_prescale) begin
      prescale_q <= prescale_merged[PRESCALE_W-1:0];
    end
  end

  clint_prescaler #(
    .W (PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (timer_en),
    .div   (prescale_q),
    .clr   (wr_prescale),
    .tick  (tick)
  );

  // Written byte lanes override the increment; untouched lanes keep the
  // incremented value, so a low-word write still lets a carry reach the high word.
  logic [63:0] mtime_q, mtime_inc, mtime_d;

  assign mtime_inc = mtime_q + {63'd0, tick};

  always_comb begin
    mtime_d = mtime_inc;
    if (wr_mtime_lo) begin
      mtime_d[31:0] = byte_merge(mtime_inc[31:0], wdata, wstrb);
    end
    if (wr_mtime_hi) begin
      mtime_d[63:32] = byte_merge(mtime_inc[63:32], wdata, wstrb);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime_q <= '0;
    end else begin
      mtime_q <= mtime_d;
    end
  end

  logic [63:0] cmp_arr [NUM_HARTS];

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    logic        wr_msip, wr_cmp_lo, wr_cmp_hi;
    logic        sw_q, ex_q, tirq_q;
    logic [63:0] cmp_q;
    logic [31:0] msip_merged;
    logic        unused_msip_bits;

    assign wr_msip   = wr_en && w_msip_rgn && (w_msip_idx == HIDX_W'(h));
    assign wr_cmp_lo = wr_en && w_cmp_rgn && (w_cmp_idx == HIDX_W'(h)) && !woff[2];
    assign wr_cmp_hi = wr_en && w_cmp_rgn && (w_cmp_idx == HIDX_W'(h)) && woff[2];

    assign msip_merged      = byte_merge({15'd0, ex_q, 15'd0, sw_q}, wdata, wstrb);
    assign unused_msip_bits = ^{msip_merged[31:17], msip_merged[15:1]};

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sw_q   <= 1'b0;
        ex_q   <= 1'b0;
        cmp_q  <= '1;
        tirq_q <= 1'b0;
      end else begin
        if (wr_msip) begin
          sw_q <= msip_merged[0];
          ex_q <= msip_merged[16];
        end
        if (wr_cmp_lo) begin
          cmp_q[31:0] <= byte_merge(cmp_q[31:0], wdata, wstrb);
        end
        if (wr_cmp_hi) begin
          cmp_q[63:32] <= byte_merge(cmp_q[63:32], wdata, wstrb);
        end
        tirq_q <= (mtime_q >= cmp_q);
      end
    end

    assign sw_irq[h]    = sw_q;
    assign ex_irq[h]    = ex_q;
    assign timer_irq[h] = tirq_q;
    assign cmp_arr[h]   = cmp_q;
  end

  logic              rhit;
  logic [15:0]       roff;
  logic [HIDX_W-1:0] r_msip_idx, r_cmp_idx;
  logic              r_msip_rgn, r_cmp_rgn;
  logic [31:0]       rmux;

  assign rhit       = (raddr[31:16] == BASE_ADDR[31:16]);
  assign roff       = {raddr[15:2], 2'b00};
  assign r_msip_idx = roff[2 +: HIDX_W];
  assign r_cmp_idx  = roff[3 +: HIDX_W];
  assign r_msip_rgn = (roff[15:2+HIDX_W] == MSIP_OFF[15:2+HIDX_W]);
  assign r_cmp_rgn  = (roff[15:3+HIDX_W] == MTIMECMP_OFF[15:3+HIDX_W]);

  // Muxes current register values, so a same-cycle write is not visible yet.
  always_comb begin
    rmux = '0;
    if (rhit) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (r_msip_rgn && (int'(r_msip_idx) == h)) begin
          rmux = {15'd0, ex_irq[h], 15'd0, sw_irq[h]};
        end
        if (r_cmp_rgn && (int'(r_cmp_idx) == h)) begin
          rmux = roff[2] ? cmp_arr[h][63:32] : cmp_arr[h][31:0];
        end
      end
      if (roff == PRESCALE_OFF) begin
        rmux = prescale_ext;
      end
      if (roff == MTIME_OFF) begin
        rmux = mtime_q[31:0];
      end
      if (roff == MTIME_OFF + 16'd4) begin
        rmux = mtime_q[63:32];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rresp <= 1'b0;
      rdata <= '0;
    end else begin
      rresp <= rready;
      if (rready) begin
        rdata <= rmux;
      end
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - self-checking bench for clint_timer with two harts
module tb_clint_timer;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        timer_en = 1'b0;
  logic        wready = 1'b0;
  logic        wvalid;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        rready = 1'b0;
  logic        rvalid;
  logic [31:0] raddr = '0;
  logic        rresp;
  logic [31:0] rdata;
  logic [1:0]  timer_irq, sw_irq, ex_irq;

  int n_tests = 0;
  int n_fail  = 0;

  clint_timer #(
    .NUM_HARTS  (2),
    .BASE_ADDR  (BASE),
    .PRESCALE_W (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .timer_en  (timer_en),
    .wready    (wready),
    .wvalid    (wvalid),
    .waddr     (waddr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .rready    (rready),
    .rvalid    (rvalid),
    .raddr     (raddr),
    .rresp     (rresp),
    .rdata     (rdata),
    .timer_irq (timer_irq),
    .sw_irq    (sw_irq),
    .ex_irq    (ex_irq)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] off, input logic [31:0] d, input logic [3:0] s);
    waddr  = BASE + {16'h0, off};
    wdata  = d;
    wstrb  = s;
    wready = 1'b1;
    cycle();
    wready = 1'b0;
    wstrb  = 4'h0;
  endtask

  task automatic rd(input logic [15:0] off, output logic [31:0] d, output logic resp);
    raddr  = BASE + {16'h0, off};
    rready = 1'b1;
    cycle();
    d      = rdata;
    resp   = rresp;
    rready = 1'b0;
  endtask

  task automatic do_reset();
    timer_en = 1'b0;
    wready   = 1'b0;
    rready   = 1'b0;
    reset    = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        r;
    do_reset();
    n_tests++;
    if ({timer_irq, sw_irq, ex_irq} !== 6'b0) begin
      n_fail++; $display("FAIL reset_irqs: got %b expected 000000", {timer_irq, sw_irq, ex_irq});
    end
    n_tests++;
    if ({rresp, rdata} !== 33'b0) begin
      n_fail++; $display("FAIL reset_read_port: got %b/%h expected 0/00000000", rresp, rdata);
    end
    rd(16'h4000, d, r);
    n_tests++;
    if (d !== 32'hFFFF_FFFF || r !== 1'b1) begin
      n_fail++; $display("FAIL reset_mtimecmp0: got %h resp %b expected ffffffff resp 1", d, r);
    end
    cycle();
    n_tests++;
    if (rresp !== 1'b0 || rdata !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL read_idle_hold: got %b/%h expected 0/ffffffff", rresp, rdata);
    end
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    logic        r;
    wr(16'hBFF0, 32'd3, 4'hF);
    timer_en = 1'b1;
    repeat (40) cycle();
    timer_en = 1'b0;
    rd(16'hBFF8, d, r);
    n_tests++;
    if (d !== 32'd10) begin
      n_fail++; $display("FAIL prescale3_40cyc: got %0d expected 10", d);
    end
    repeat (5) cycle();
    rd(16'hBFF8, d, r);
    n_tests++;
    if (d !== 32'd10) begin
      n_fail++; $display("FAIL frozen_when_disabled: got %0d expected 10", d);
    end
  endtask

  task automatic test_carry();
    logic [31:0] lo, hi;
    logic        r;
    wr(16'hBFF0, 32'd0, 4'hF);
    wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    wr(16'hBFFC, 32'd0, 4'hF);
    timer_en = 1'b1;
    cycle();
    timer_en = 1'b0;
    rd(16'hBFF8, lo, r);
    rd(16'hBFFC, hi, r);
    n_tests++;
    if (lo !== 32'd0 || hi !== 32'd1) begin
      n_fail++; $display("FAIL carry_32: got %h_%h expected 00000001_00000000", hi, lo);
    end
    wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    timer_en = 1'b1;
    cycle();
    timer_en = 1'b0;
    rd(16'hBFF8, lo, r);
    rd(16'hBFFC, hi, r);
    n_tests++;
    if (lo !== 32'd0 || hi !== 32'd0) begin
      n_fail++; $display("FAIL wrap_64: got %h_%h expected 00000000_00000000", hi, lo);
    end
  endtask

  task automatic test_hart_cmp();
    int first_seen = -1;
    bit hart0_seen = 0;
    wr(16'hBFF8, 32'd0, 4'hF);
    wr(16'hBFFC, 32'd0, 4'hF);
    wr(16'h4008, 32'd20, 4'hF);
    wr(16'h400C, 32'd0, 4'hF);
    n_tests++;
    if (timer_irq !== 2'b00) begin
      n_fail++; $display("FAIL cmp_idle: got %b expected 00", timer_irq);
    end
    timer_en = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (timer_irq[1] === 1'b1 && first_seen < 0) first_seen = i;
      if (timer_irq[0] !== 1'b0) hart0_seen = 1;
    end
    timer_en = 1'b0;
    n_tests++;
    if (first_seen != 21) begin
      n_fail++; $display("FAIL irq1_first_cycle: got %0d expected 21", first_seen);
    end
    n_tests++;
    if (hart0_seen) begin
      n_fail++; $display("FAIL irq0_quiet: got raised expected never");
    end
    wr(16'h4008, 32'd100, 4'hF);
    n_tests++;
    if (timer_irq !== 2'b10) begin
      n_fail++; $display("FAIL irq1_on_write_edge: got %b expected 10", timer_irq);
    end
    cycle();
    n_tests++;
    if (timer_irq !== 2'b00) begin
      n_fail++; $display("FAIL irq1_drop: got %b expected 00", timer_irq);
    end
  endtask

  task automatic test_msip();
    logic [31:0] d;
    logic        r;
    wr(16'h0004, 32'h0001_0001, 4'b0001);
    n_tests++;
    if (sw_irq !== 2'b10 || ex_irq !== 2'b00) begin
      n_fail++; $display("FAIL msip_lane0: got sw %b ex %b expected sw 10 ex 00", sw_irq, ex_irq);
    end
    wr(16'h0004, 32'h0001_0001, 4'b0100);
    n_tests++;
    if (sw_irq !== 2'b10 || ex_irq !== 2'b10) begin
      n_fail++; $display("FAIL msip_lane2: got sw %b ex %b expected sw 10 ex 10", sw_irq, ex_irq);
    end
    wr(16'h0004, 32'h0000_0000, 4'b0000);
    rd(16'h0004, d, r);
    n_tests++;
    if (d !== 32'h0001_0001) begin
      n_fail++; $display("FAIL msip_strb0_noop: got %h expected 00010001", d);
    end
    wr(16'h0004, 32'hFFFF_FFFE, 4'hF);
    rd(16'h0004, d, r);
    n_tests++;
    if (d !== 32'h0001_0000 || sw_irq !== 2'b00) begin
      n_fail++; $display("FAIL msip_mask: got %h sw %b expected 00010000 sw 00", d, sw_irq);
    end
    wr(16'h0004, 32'd0, 4'hF);
  endtask

  task automatic test_write_during_tick();
    logic [31:0] d;
    logic        r;
    wr(16'hBFF8, 32'd10, 4'hF);
    timer_en = 1'b1;
    wr(16'hBFF8, 32'd5, 4'hF);
    timer_en = 1'b0;
    rd(16'hBFF8, d, r);
    n_tests++;
    if (d !== 32'd5) begin
      n_fail++; $display("FAIL write_beats_tick: got %0d expected 5", d);
    end
    wr(16'hBFF8, 32'h0000_01FF, 4'hF);
    timer_en = 1'b1;
    wr(16'hBFF8, 32'h0000_00AA, 4'b0001);
    timer_en = 1'b0;
    rd(16'hBFF8, d, r);
    n_tests++;
    if (d !== 32'h0000_02AA) begin
      n_fail++; $display("FAIL lane_mix_tick: got %h expected 000002aa", d);
    end
    wr(16'h4010, 32'd0, 4'hF);
    wr(16'h0008, 32'd1, 4'hF);
    rd(16'h4010, d, r);
    n_tests++;
    if (d !== 32'd0 || r !== 1'b1) begin
      n_fail++; $display("FAIL unmapped_read: got %h resp %b expected 00000000 resp 1", d, r);
    end
    rd(16'h4000, d, r);
    n_tests++;
    if (d !== 32'hFFFF_FFFF || sw_irq !== 2'b00) begin
      n_fail++; $display("FAIL unmapped_write: got %h sw %b expected ffffffff sw 00", d, sw_irq);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        r;
    wr(16'hBFF8, 32'd7, 4'hF);
    waddr  = BASE + 32'hBFF8;
    wdata  = 32'd9;
    wstrb  = 4'hF;
    wready = 1'b1;
    raddr  = BASE + 32'hBFF8;
    rready = 1'b1;
    cycle();
    wready = 1'b0;
    rready = 1'b0;
    n_tests++;
    if (rdata !== 32'd7) begin
      n_fail++; $display("FAIL rw_same_cycle: got %0d expected 7", rdata);
    end
    rd(16'hBFF8, d, r);
    n_tests++;
    if (d !== 32'd9) begin
      n_fail++; $display("FAIL read_after_write: got %0d expected 9", d);
    end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] d;
    logic        r;
    wr(16'h0004, 32'd1, 4'hF);
    wr(16'hBFF0, 32'd2, 4'hF);
    timer_en = 1'b1;
    repeat (5) cycle();
    #2;
    reset    = 1'b1;
    timer_en = 1'b0;
    #1;
    n_tests++;
    if (sw_irq !== 2'b00 || timer_irq !== 2'b00) begin
      n_fail++; $display("FAIL async_reset: got sw %b timer %b expected 00 00", sw_irq, timer_irq);
    end
    cycle();
    reset = 1'b0;
    cycle();
    wr(16'hBFF0, 32'd4, 4'hF);
    timer_en = 1'b1;
    repeat (4) cycle();
    timer_en = 1'b0;
    rd(16'hBFF8, d, r);
    n_tests++;
    if (d !== 32'd0) begin
      n_fail++; $display("FAIL post_reset_pre_tick: got %0d expected 0", d);
    end
    timer_en = 1'b1;
    cycle();
    timer_en = 1'b0;
    rd(16'hBFF8, d, r);
    n_tests++;
    if (d !== 32'd1) begin
      n_fail++; $display("FAIL post_reset_first_tick: got %0d expected 1", d);
    end
  endtask

  // Reference model state for the random run.
  logic [63:0] m_mtime;
  logic [63:0] m_cmp [2];
  logic [31:0] m_msip [2];
  logic [31:0] m_ps, m_pcnt, m_rdata;

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [31:0] apply(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    return (old & ~lane_mask(s)) | (d & lane_mask(s));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:16] != BASE[31:16]) return 32'd0;
    case (a[15:0])
      16'h0000: return m_msip[0];
      16'h0004: return m_msip[1];
      16'h4000: return m_cmp[0][31:0];
      16'h4004: return m_cmp[0][63:32];
      16'h4008: return m_cmp[1][31:0];
      16'h400C: return m_cmp[1][63:32];
      16'hBFF0: return m_ps;
      16'hBFF8: return m_mtime[31:0];
      16'hBFFC: return m_mtime[63:32];
      default:  return 32'd0;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] addr_tbl [12];
    logic [31:0] wa, wd, ra, exp_rd;
    logic [3:0]  ws;
    logic        en, do_wr, do_rd, tick, pclr;
    logic [1:0]  exp_irq;
    logic [63:0] mt_n;
    int          wi;
    addr_tbl = '{BASE + 32'h0000, BASE + 32'h0004, BASE + 32'h0008, BASE + 32'h4000,
                 BASE + 32'h4004, BASE + 32'h4008, BASE + 32'h400C, BASE + 32'h4010,
                 BASE + 32'hBFF0, BASE + 32'hBFF8, BASE + 32'hBFFC, 32'h0300_BFF8};
    do_reset();
    m_mtime = '0;
    m_cmp[0] = '1;
    m_cmp[1] = '1;
    m_msip[0] = '0;
    m_msip[1] = '0;
    m_ps = '0;
    m_pcnt = '0;
    m_rdata = '0;
    for (int i = 0; i < 800; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      do_wr = ($urandom_range(0, 2) == 0);
      do_rd = ($urandom_range(0, 1) == 1);
      wi    = int'($urandom_range(0, 11));
      wa    = addr_tbl[wi];
      ra    = addr_tbl[$urandom_range(0, 11)];
      ws    = 4'($urandom_range(0, 15));
      case (wi)
        3, 5, 9: wd = $urandom_range(0, 80);
        4, 6, 10: wd = $urandom_range(0, 1);
        8:        wd = $urandom_range(0, 3);
        default:  wd = $urandom;
      endcase
      exp_rd  = m_read(ra);
      tick    = en && (m_pcnt == m_ps);
      exp_irq = {m_mtime >= m_cmp[1], m_mtime >= m_cmp[0]};
      mt_n    = m_mtime + 64'(tick);
      pclr    = 1'b0;
      if (do_wr && wa[31:16] == BASE[31:16]) begin
        case (wa[15:0])
          16'h0000: m_msip[0] = apply(m_msip[0], wd, ws) & 32'h0001_0001;
          16'h0004: m_msip[1] = apply(m_msip[1], wd, ws) & 32'h0001_0001;
          16'h4000: m_cmp[0][31:0]  = apply(m_cmp[0][31:0], wd, ws);
          16'h4004: m_cmp[0][63:32] = apply(m_cmp[0][63:32], wd, ws);
          16'h4008: m_cmp[1][31:0]  = apply(m_cmp[1][31:0], wd, ws);
          16'h400C: m_cmp[1][63:32] = apply(m_cmp[1][63:32], wd, ws);
          16'hBFF0: begin
            m_ps = apply(m_ps, wd, ws) & 32'h0000_FFFF;
            pclr = (ws != 4'h0);
          end
          16'hBFF8: mt_n[31:0]  = apply(mt_n[31:0], wd, ws);
          16'hBFFC: mt_n[63:32] = apply(mt_n[63:32], wd, ws);
          default: ;
        endcase
      end
      m_mtime = mt_n;
      if (pclr) m_pcnt = 0;
      else if (en) m_pcnt = tick ? 32'd0 : m_pcnt + 1;
      if (do_rd) m_rdata = exp_rd;
      timer_en = en;
      wready   = do_wr;
      waddr    = wa;
      wdata    = wd;
      wstrb    = ws;
      rready   = do_rd;
      raddr    = ra;
      cycle();
      n_tests++;
      if (timer_irq !== exp_irq || sw_irq !== {m_msip[1][0], m_msip[0][0]} ||
          ex_irq !== {m_msip[1][16], m_msip[0][16]}) begin
        n_fail++;
        $display("FAIL rand_irqs[%0d]: got t%b s%b e%b expected t%b s%b e%b", i, timer_irq,
                 sw_irq, ex_irq, exp_irq, {m_msip[1][0], m_msip[0][0]},
                 {m_msip[1][16], m_msip[0][16]});
      end
      n_tests++;
      if (rresp !== do_rd || rdata !== m_rdata) begin
        n_fail++;
        $display("FAIL rand_read[%0d] addr %h: got %b/%h expected %b/%h", i, ra, rresp, rdata,
                 do_rd, m_rdata);
      end
    end
    timer_en = 1'b0;
    wready   = 1'b0;
    rready   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_carry();
    test_hart_cmp();
    test_msip();
    test_write_during_tick();
    test_back_to_back();
    test_reset_midcount();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
